serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder: a, b and c_in are latched on start, then summed

---
 rtl/serial_adder.sv | 174 +++++++++++++++++
 tb/tb_serial_adder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder.
// Operands are captured on an accepted start, then summed DIGIT bits per clock
// through a DIGIT-stage ripple chain. The carry is held in a register between
// slices. A start/busy/done handshake connects the block to its controlling FSM.
// The registered result (sum, c_out, overflow) changes only on the edge that
// raises done, so a consumer can read it at any time after the pulse.

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    // Number of slices, i.e. clock cycles spent in RUN for one add.
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Refuse to elaborate a slice width that does not tile the operand.
    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ripple-carry add of one DIGIT-bit slice.
    // Returns {carry out of slice, carry into slice MSB, slice sum}.
    // The carry into the slice MSB is what the signed overflow test needs on
    // the final slice; for DIGIT=1 it is simply the slice carry-in.
    function automatic logic [DIGIT+1:0] add_slice(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             ci
    );
        logic [DIGIT:0]   c;
        logic [DIGIT-1:0] s;
        c    = {(DIGIT + 1){1'b0}};
        s    = {DIGIT{1'b0}};
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[DIGIT], c[DIGIT-1], s};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;        // operand A, shifted right one slice per RUN cycle
    logic [WIDTH-1:0]   b_r;        // operand B, shifted right one slice per RUN cycle
    logic               cin_r;      // carry-in captured at accept, feeds slice 0
    logic               carry_r;    // carry between slices
    logic [CNT_W-1:0]   cnt_r;      // index of the slice being added
    logic [WIDTH-1:0]   acc_r;      // partial result, filled from the top
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               c_out_r;
    logic               overflow_r;

    logic               slice_cin_s;
    logic [DIGIT+1:0]   slice_res_s;
    logic [DIGIT-1:0]   slice_sum_s;
    logic               slice_cout_s;
    logic               slice_cmsb_s;
    logic [WIDTH-1:0]   slice_wide_s;
    logic [WIDTH-1:0]   acc_next_s;

    // Slice datapath: pick the carry-in, add the low slice, merge into the result.
    always_comb begin
        slice_cin_s  = 1'b0;
        slice_wide_s = {WIDTH{1'b0}};
        if (cnt_r == CNT_ZERO) begin
            slice_cin_s = cin_r;
        end else begin
            slice_cin_s = carry_r;
        end
        slice_res_s  = add_slice(a_r[DIGIT-1:0], b_r[DIGIT-1:0], slice_cin_s);
        slice_sum_s  = slice_res_s[DIGIT-1:0];
        slice_cmsb_s = slice_res_s[DIGIT];
        slice_cout_s = slice_res_s[DIGIT+1];
        slice_wide_s[DIGIT-1:0] = slice_sum_s;
        // New slice enters at the top; after N shifts slice 0 sits at bit 0.
        acc_next_s   = (acc_r >> DIGIT) | (slice_wide_s << (WIDTH - DIGIT));
    end

    // Control FSM, operand/carry registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            cin_r      <= 1'b0;
            carry_r    <= 1'b0;
            cnt_r      <= CNT_ZERO;
            acc_r      <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sum_r      <= {WIDTH{1'b0}};
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless the final slice completes now.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        cin_r   <= c_in;
                        carry_r <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                        acc_r   <= {WIDTH{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start and the operand inputs are deliberately ignored here.
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= slice_cout_s;
                    acc_r   <= acc_next_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        sum_r      <= acc_next_s;
                        c_out_r    <= slice_cout_s;
                        overflow_r <= slice_cmsb_s ^ slice_cout_s;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder: one instance slicing 1 bit per cycle,
// one slicing 4 bits per cycle, with hand-computed expected results.

module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start1;
    logic       start4;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin_in;

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    int checks;
    int errors;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a_in), .b(b_in), .c_in(cin_in),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .overflow(ovf1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a(a_in), .b(b_in), .c_in(cin_in),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .overflow(ovf4)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one add from a negedge; returns at the negedge where done is seen
    // (or after a bounded wait), checking latency and busy length.
    task automatic do_add(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input int exp_lat, input string tag);
        int cyc;
        int busy_n;
        a_in   = av;
        b_in   = bv;
        cin_in = cv;
        if (wide) start4 = 1'b1;
        else      start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        cyc    = 1;
        busy_n = 0;
        while (!(wide ? done4 : done1) && cyc < 40) begin
            if (wide ? busy4 : busy1) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check_value({tag, " latency"}, cyc - 1, exp_lat);
        check_value({tag, " busy cycles"}, busy_n, exp_lat);
        check_value({tag, " busy at done"}, {31'd0, (wide ? busy4 : busy1)}, 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        a_in   = 8'h00;
        b_in   = 8'h00;
        cin_in = 1'b0;

        // 1. reset for 3 cycles, then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst busy", {31'd0, busy1}, 32'd0);
        check_value("rst done", {31'd0, done1}, 32'd0);
        check_value("rst sum", {24'd0, sum1}, 32'd0);
        check_value("rst c_out", {31'd0, cout1}, 32'd0);
        check_value("rst overflow", {31'd0, ovf1}, 32'd0);
        check_value("rst sum4", {24'd0, sum4}, 32'd0);
        repeat (4) @(negedge clk);
        check_value("idle busy", {30'd0, busy1, busy4}, 32'd0);
        check_value("idle done", {30'd0, done1, done4}, 32'd0);

        // 2. FF + 01 wraps to 00 with carry out
        do_add(1'b0, 8'hFF, 8'h01, 1'b0, 8, "ff+01");
        check_value("ff+01 sum", {24'd0, sum1}, 32'h00);
        check_value("ff+01 c_out", {31'd0, cout1}, 32'd1);
        check_value("ff+01 overflow", {31'd0, ovf1}, 32'd0);
        @(negedge clk);
        check_value("ff+01 done pulse width", {31'd0, done1}, 32'd0);

        // 3. 7F + 01 signed overflow, result held while idle
        do_add(1'b0, 8'h7F, 8'h01, 1'b0, 8, "7f+01");
        check_value("7f+01 sum", {24'd0, sum1}, 32'h80);
        check_value("7f+01 c_out", {31'd0, cout1}, 32'd0);
        check_value("7f+01 overflow", {31'd0, ovf1}, 32'd1);
        a_in = 8'h33;
        b_in = 8'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("7f+01 sum hold", {24'd0, sum1}, 32'h80);
        end

        // carry-in path: 80 + 80 + 1 = 0x101
        do_add(1'b0, 8'h80, 8'h80, 1'b1, 8, "80+80+1");
        check_value("80+80+1 sum", {24'd0, sum1}, 32'h01);
        check_value("80+80+1 c_out", {31'd0, cout1}, 32'd1);
        check_value("80+80+1 overflow", {31'd0, ovf1}, 32'd1);

        // 4. DIGIT=4: A5 + 5A + 1 = 0x100
        do_add(1'b1, 8'hA5, 8'h5A, 1'b1, 2, "d4 a5+5a+1");
        check_value("d4 sum", {24'd0, sum4}, 32'h00);
        check_value("d4 c_out", {31'd0, cout4}, 32'd1);
        check_value("d4 overflow", {31'd0, ovf4}, 32'd0);
        do_add(1'b1, 8'h7F, 8'h01, 1'b0, 2, "d4 7f+01");
        check_value("d4 7f+01 sum", {24'd0, sum4}, 32'h80);
        check_value("d4 7f+01 overflow", {31'd0, ovf4}, 32'd1);
        @(negedge clk);

        // 5. start during busy is ignored; back-to-back start in done cycle
        a_in   = 8'h03;
        b_in   = 8'h04;
        cin_in = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc    = 1;
        while (!done1 && cyc < 40) begin
            if (cyc == 3) begin
                a_in   = 8'h10;
                b_in   = 8'h10;
                start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
        check_value("3+4 latency", cyc - 1, 8);
        check_value("3+4 sum", {24'd0, sum1}, 32'h07);
        do_add(1'b0, 8'h10, 8'h10, 1'b0, 8, "b2b 10+10");
        check_value("b2b sum", {24'd0, sum1}, 32'h20);
        check_value("b2b c_out", {31'd0, cout1}, 32'd0);

        // 6. reset aborts an add in progress
        @(negedge clk);
        a_in   = 8'hF0;
        b_in   = 8'h0F;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_value("abort busy before rst", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        #1;
        check_value("abort busy", {31'd0, busy1}, 32'd0);
        check_value("abort done", {31'd0, done1}, 32'd0);
        check_value("abort sum", {24'd0, sum1}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done1 || busy1) saw_done = 1'b1;
        end
        check_value("abort no done", {31'd0, saw_done}, 32'd0);
        do_add(1'b0, 8'hF0, 8'h0F, 1'b0, 8, "f0+0f");
        check_value("f0+0f sum", {24'd0, sum1}, 32'hFF);
        check_value("f0+0f c_out", {31'd0, cout1}, 32'd0);
        check_value("f0+0f overflow", {31'd0, ovf1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
